// File: rtl/gromitsys_osc_freq_mon.sv
// ---------------------------------------------------------------------------
// gromitsys_osc_freq_mon
// Counts rising edges of an asynchronous oscillator (MEAS_CLK) over a fixed
// window of CLK cycles, reports each count, flags out-of-range windows and
// raises a sticky FAULT after FAIL_LIMIT consecutive bad windows.
//
// Ports:
//   CLK          in   fabric clock
//   RESET_N      in   asynchronous active-low reset
//   MEAS_CLK     in   clock under test (asynchronous, below CLK/4)
//   ENABLE       in   level, 1 = run windows continuously
//   CLR_FAULT    in   pulse, clears FAULT and the bad-window count
//   EDGE_COUNT   out  edge count of the last completed window
//   COUNT_VALID  out  one-cycle pulse when EDGE_COUNT updates
//   IN_RANGE     out  range result of the last completed window
//   FAULT        out  sticky oscillator fault
//   BUSY         out  high in SETTLE, MEASURE and EVAL
// ---------------------------------------------------------------------------
module gromitsys_osc_freq_mon #(
   parameter int unsigned WINDOW_CYCLES = 50000,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned EXP_MIN       = 990,
   parameter int unsigned EXP_MAX       = 1010,
   parameter int unsigned FAIL_LIMIT    = 2,    // 1..15
   parameter int unsigned SETTLE_CYCLES = 256
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             MEAS_CLK,
   input  logic             ENABLE,
   input  logic             CLR_FAULT,
   output logic [CNT_W-1:0] EDGE_COUNT,
   output logic             COUNT_VALID,
   output logic             IN_RANGE,
   output logic             FAULT,
   output logic             BUSY
);

   localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES + 1);
   localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned BAD_W = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_MEASURE = 2'd2,
      S_EVAL    = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [2:0]         r_sync;
   logic               w_edge;
   logic [SET_W-1:0]   r_settle_cnt;
   logic [WIN_W-1:0]   r_win_cnt;
   logic [CNT_W-1:0]   r_edge_cnt;
   logic [BAD_W-1:0]   r_bad_cnt;
   logic [BAD_W-1:0]   w_bad_next;
   logic               w_in_range;
   logic               w_set_fault;
   logic [CNT_W-1:0]   r_edge_count;
   logic               r_count_valid;
   logic               r_in_range;
   logic               r_fault;
   logic               r_busy;

   // Three-flop synchronizer; rising edge seen between flops 2 and 3
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_sync <= 3'b000;
      else          r_sync <= {r_sync[1:0], MEAS_CLK};
   end

   assign w_edge = r_sync[1] & ~r_sync[2];

   // State register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next-state logic; dropping ENABLE aborts SETTLE/MEASURE without a result
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (ENABLE) w_next = S_SETTLE;
         end
         S_SETTLE: begin
            if (!ENABLE)                                        w_next = S_IDLE;
            else if (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1)) w_next = S_MEASURE;
         end
         S_MEASURE: begin
            if (!ENABLE)                                     w_next = S_IDLE;
            else if (r_win_cnt == WIN_W'(WINDOW_CYCLES - 1)) w_next = S_EVAL;
         end
         S_EVAL: begin
            w_next = ENABLE ? S_MEASURE : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Settle/window/edge counters; held at zero outside their own state so
   // every SETTLE and MEASURE entry starts from a clean count
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_settle_cnt <= '0;
         r_win_cnt    <= '0;
         r_edge_cnt   <= '0;
      end else begin
         r_settle_cnt <= (r_state == S_SETTLE) ? r_settle_cnt + SET_W'(1) : '0;
         r_win_cnt    <= (r_state == S_MEASURE) ? r_win_cnt + WIN_W'(1) : '0;
         if (r_state == S_MEASURE) begin
            if (w_edge && (r_edge_cnt != '1)) r_edge_cnt <= r_edge_cnt + CNT_W'(1);
         end else if (r_state != S_EVAL) begin
            r_edge_cnt <= '0;
         end else begin
            r_edge_cnt <= '0;  // consumed by the EVAL update below
         end
      end
   end

   // Window evaluation, computed during EVAL from the completed count
   always_comb begin
      w_in_range = (32'(r_edge_cnt) >= EXP_MIN) && (32'(r_edge_cnt) <= EXP_MAX);
      w_bad_next = r_bad_cnt;
      if (w_in_range)                              w_bad_next = '0;
      else if (r_bad_cnt < BAD_W'(FAIL_LIMIT))     w_bad_next = r_bad_cnt + BAD_W'(1);
      w_set_fault = !w_in_range && (w_bad_next == BAD_W'(FAIL_LIMIT));
   end

   // Result, fault and status registers; a fault set in EVAL beats CLR_FAULT
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_edge_count  <= '0;
         r_count_valid <= 1'b0;
         r_in_range    <= 1'b0;
         r_fault       <= 1'b0;
         r_bad_cnt     <= '0;
         r_busy        <= 1'b0;
      end else begin
         r_count_valid <= (r_state == S_EVAL);
         r_busy        <= (w_next != S_IDLE);
         if (r_state == S_EVAL) begin
            r_edge_count <= r_edge_cnt;
            r_in_range   <= w_in_range;
         end
         if ((r_state == S_EVAL) && w_set_fault) begin
            r_bad_cnt <= w_bad_next;
            r_fault   <= 1'b1;
         end else if (CLR_FAULT) begin
            r_bad_cnt <= '0;
            r_fault   <= 1'b0;
         end else if (r_state == S_EVAL) begin
            r_bad_cnt <= w_bad_next;
         end
      end
   end

   assign EDGE_COUNT  = r_edge_count;
   assign COUNT_VALID = r_count_valid;
   assign IN_RANGE    = r_in_range;
   assign FAULT       = r_fault;
   assign BUSY        = r_busy;

endmodule

// File: doc/gromitsys_osc_freq_mon.md
Name: gromitsys_osc_freq_mon

Overview:
- Fabric-side frequency monitor downstream of the on-chip oscillator block.
- Clocked by the 50 MHz RC oscillator fabric clock. It counts rising edges of a second, asynchronous oscillator output (normally the 1 MHz RC O2F) over a fixed window.
- Reports each window count and flags out-of-range windows.
- Raises a sticky FAULT after consecutive bad windows, so system firmware can detect a dead or drifting oscillator.

Parameters:
- WINDOW_CYCLES, 50000: CLK cycles per measurement window (1 ms at 50 MHz).
- CNT_W, 16: width of the edge counter and EDGE_COUNT.
- EXP_MIN, 990: minimum in-range edge count, inclusive.
- EXP_MAX, 1010: maximum in-range edge count, inclusive.
- FAIL_LIMIT, 2: consecutive out-of-range windows that set FAULT (range 1..15).
- SETTLE_CYCLES, 256: CLK cycles discarded after enable, before the first window.

Ports:
- CLK  in  1  50 MHz fabric clock from the RC oscillator O2F output.
- RESET_N  in  1  asynchronous, active-low reset.
- MEAS_CLK  in  1  clock under test; asynchronous to CLK; must be below CLK/4.
- ENABLE  in  1  level; 1 = run windows continuously.
- CLR_FAULT  in  1  single-cycle pulse; clears FAULT and the bad-window count.
- EDGE_COUNT  out  CNT_W  edge count of the last completed window.
- COUNT_VALID  out  1  one-cycle pulse when EDGE_COUNT updates.
- IN_RANGE  out  1  result of the last completed window.
- FAULT  out  1  sticky oscillator fault.
- BUSY  out  1  high in SETTLE, MEASURE and EVAL.

Behaviour:
- Reset (RESET_N low, asynchronous): every output is 0, state is IDLE, and all counters and synchronizer flops are 0.
- Synchronizer and edge detect:
  - MEAS_CLK passes through 3 flops in the CLK domain.
  - A rising edge is detected when flop 2 = 1 and flop 3 = 0.
  - Detection latency is 3 CLK cycles from the MEAS_CLK edge.
- IDLE: BUSY = 0. ENABLE = 1 moves to SETTLE and clears the settle counter.
- SETTLE:
  - Runs for SETTLE_CYCLES cycles; detected edges are ignored.
  - Then moves to MEASURE with the window counter and edge counter cleared.
- MEASURE:
  - Lasts exactly WINDOW_CYCLES cycles.
  - Each detected edge increments the edge counter, which saturates at 2^CNT_W-1 and does not wrap.
  - An edge detected on the last window cycle is counted.
  - After the last cycle, moves to EVAL.
- EVAL (exactly one cycle):
  - EDGE_COUNT takes the edge count and COUNT_VALID = 1 for this cycle only.
  - IN_RANGE = (EXP_MIN <= count <= EXP_MAX).
  - If out of range, the bad-window counter increments, saturating at FAIL_LIMIT. If in range, it clears to 0.
  - FAULT is set when the bad-window counter reaches FAIL_LIMIT.
  - Edges detected during EVAL are discarded.
  - Next state is MEASURE (counters cleared, back-to-back windows with period WINDOW_CYCLES+1) if ENABLE = 1, else IDLE.
- ENABLE low in SETTLE or MEASURE: return to IDLE on the next edge. There is no COUNT_VALID pulse. EDGE_COUNT, IN_RANGE, FAULT and the bad-window counter hold.
- Re-enable: always passes through SETTLE again.
- CLR_FAULT:
  - Clears FAULT and the bad-window counter in any state.
  - If it coincides with EVAL setting FAULT, the set wins: FAULT = 1 and the counter holds its new value.
- Stuck MEAS_CLK (high or low) gives count 0, which is out of range. This is the primary dead-oscillator detection path.
- Reset mid-window: asynchronous clear to reset values. No partial result is reported.

Test Plan:
1. 1 MHz MEAS_CLK, ENABLE = 1, defaults:
   - First COUNT_VALID arrives SETTLE_CYCLES+WINDOW_CYCLES+1 cycles after ENABLE (±1 for the IDLE exit).
   - EDGE_COUNT is in 999..1001, IN_RANGE = 1, FAULT = 0.
   - Subsequent pulses occur every 50001 cycles.
2. MEAS_CLK held at 0:
   - Window 1 gives EDGE_COUNT = 0, IN_RANGE = 0, FAULT = 0.
   - Window 2 gives FAULT = 1, which stays 1 after the clock is restored and good windows follow.
3. Windows of 1.1 MHz, then 1 MHz, then 1.1 MHz:
   - Counts are ~1100 (IN_RANGE = 0), ~1000 (IN_RANGE = 1), ~1100 (IN_RANGE = 0).
   - FAULT never sets because the bad-window counter is reset by the good window.
4. ENABLE dropped at window cycle 20000:
   - No COUNT_VALID pulse; BUSY = 0 on the next cycle; EDGE_COUNT keeps the previous value.
   - Re-enable produces a full SETTLE, then a normal window.
5. With FAULT = 1, pulse CLR_FAULT: FAULT = 0 next cycle. Then drive CLR_FAULT in the same cycle as an EVAL that reaches FAIL_LIMIT: FAULT = 1.
6. CNT_W = 4 with 1 MHz input: EDGE_COUNT saturates at 15 and does not wrap. Separately, assert RESET_N mid-MEASURE: all outputs are 0 immediately and state is IDLE.
